// File: rtl/neuron_result_reader.sv
// -----------------------------------------------------------------------------
// neuron_result_reader
//
// Drains a block of neuron values from the read port of the neuron RAM and
// delivers them to the host over a valid/ready stream. While the values pass
// through, it keeps the signed maximum and the index of the beat that first
// reached it, so the winning class is ready when the drain completes.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         synchronous active-low reset
//   start         one-cycle drain request, ignored while busy
//   base_addr     first RAM address, captured on an accepted start
//   count         number of neurons to read (0 allowed), captured on start
//   rd_en         RAM read strobe
//   rd_addr       RAM read address, wraps modulo 2^ADDR_W
//   rd_data       RAM read data, valid the cycle after rd_en
//   out_valid     stream beat valid
//   out_ready     downstream accepts the beat
//   out_data      neuron value of the current beat
//   out_index     beat number 0..count-1 (not the RAM address)
//   out_last      current beat is the final one
//   busy          drain in progress (RUN or FINISH)
//   done          one-cycle pulse when the drain finishes
//   argmax_index  beat index of the largest value seen
//   argmax_value  largest value seen, two's complement
// -----------------------------------------------------------------------------
module neuron_result_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] argmax_index,
    output logic [DATA_W-1:0] argmax_value
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Most negative two's complement value: the argmax starting point.
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    state_e            state_q, state_d;

    // Drain parameters captured on an accepted start.
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] count_q, count_d;

    // issue_cnt counts RAM reads launched, beat_cnt counts beats delivered.
    logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;

    // A read launched last cycle whose data is on rd_data this cycle.
    logic              inflight_q, inflight_d;

    // Two-entry FIFO between the RAM read port and the stream.
    logic [DATA_W-1:0] fifo_mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;

    logic [ADDR_W-1:0] amax_idx_q, amax_idx_d;
    logic [DATA_W-1:0] amax_val_q, amax_val_d;

    logic              start_acc;
    logic              push;
    logic              pop;
    logic              window_ok;
    logic              issue;
    logic              last_beat;
    logic              better;

    // -------------------------------------------------------------------------
    // Handshake and read-issue decode
    // -------------------------------------------------------------------------
    assign start_acc = (state_q == ST_IDLE) && start;

    // Data for the read launched last cycle is on rd_data now.
    assign push = inflight_q;

    // Valid depends only on registered state, never on out_ready.
    assign out_valid = (state_q == ST_RUN) && (occ_q != 2'd0);
    assign pop       = out_valid && out_ready;

    assign last_beat = (beat_cnt_q == (count_q - ADDR_W'(1)));

    // Entries held or owed (FIFO + in-flight), less the one leaving this
    // cycle, must stay below the FIFO depth for a new read to be safe.
    // Written as occ + inflight < 2 + pop so the sum never underflows.
    assign window_ok = (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    assign issue   = (state_q == ST_RUN) && (issue_cnt_q < count_q) && window_ok;
    assign rd_en   = issue;
    assign rd_addr = base_q + issue_cnt_q;   // wraps naturally at 2^ADDR_W

    // Payload is forced to zero while no beat is presented, so the outputs
    // read 0 out of reset even though the FIFO storage itself is not reset.
    assign out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign out_index = out_valid ? beat_cnt_q : '0;
    assign out_last  = out_valid && last_beat;

    // Strict compare: an equal value later in the stream never displaces
    // an earlier one, so ties resolve to the lowest index.
    assign better = ($signed(out_data) > $signed(amax_val_q));

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_FINISH);
    assign argmax_index = amax_idx_q;
    assign argmax_value = amax_val_q;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop && last_beat) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next state
    // -------------------------------------------------------------------------
    always_comb begin
        base_d      = base_q;
        count_d     = count_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        inflight_d  = issue;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        amax_idx_d  = amax_idx_q;
        amax_val_d  = amax_val_q;

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (issue) begin
            issue_cnt_d = issue_cnt_q + ADDR_W'(1);
        end

        if (pop) begin
            beat_cnt_d = beat_cnt_q + ADDR_W'(1);
            if (better) begin
                amax_idx_d = beat_cnt_q;
                amax_val_d = out_data;
            end
        end

        // Only reachable in IDLE, where no read, push or pop is active, so
        // these overrides never collide with the updates above.
        if (start_acc) begin
            base_d      = base_addr;
            count_d     = count;
            issue_cnt_d = '0;
            beat_cnt_d  = '0;
            amax_idx_d  = '0;
            amax_val_d  = MIN_VAL;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= '0;
            amax_idx_q  <= '0;
            amax_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            amax_idx_q  <= amax_idx_d;
            amax_val_q  <= amax_val_d;
        end
    end

    // NOTE: the FIFO storage is deliberately left without reset; clearing
    // occ/pointers already empties it, and stale entries are never visible
    // because the payload is masked while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= rd_data;
        end
    end

endmodule
